// File: rtl/genius_game_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : genius_pkg
// Brief    : Shared types, constants and helpers for the Genius/Simon core.
// Revision : 1.0 - initial release
// ============================================================================
package genius_pkg;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_SHOW_ON      = 3'd1,
        S_SHOW_GAP     = 3'd2,
        S_WAIT_PRESS   = 3'd3,
        S_WAIT_RELEASE = 3'd4,
        S_NEXT_LEVEL   = 3'd5,
        S_WIN          = 3'd6,
        S_LOSE         = 3'd7
    } state_e;

    // Width of a symbol index for a given button count (2..4 buttons).
    function automatic int sym_w_of(input int n_btn);
        return (n_btn <= 2) ? 1 : 2;
    endfunction

    // Width of a tick counter that must reach n-1 (at least one bit).
    function automatic int cnt_w_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // Maps the low LFSR bits onto 0..n_btn-1 with a single conditional subtract.
    function automatic logic [1:0] sym_of(input logic [15:0] lfsr, input int n_btn);
        logic [1:0] raw;
        raw = (n_btn <= 2) ? {1'b0, lfsr[0]} : lfsr[1:0];
        if (int'(raw) >= n_btn) begin
            raw = raw - 2'(n_btn);
        end
        return raw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/genius_game_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : genius_game_fsm_if
// Brief    : Player-facing signal bundle of the game core.
//            master = player/board side, slave = game core.
// Revision : 1.0 - initial release
// ============================================================================
interface genius_game_fsm_if #(
    parameter int N_BTN = 3,
    parameter int LED_W = 10
);
    import genius_pkg::*;

    localparam int SYM_W = sym_w_of(N_BTN);

    logic              start;
    logic [N_BTN-1:0]  btn;
    logic              show_valid;
    logic [SYM_W-1:0]  show_symbol;
    logic [7:0]        level;
    logic [LED_W-1:0]  leds;
    logic              win;
    logic              lose;

    modport master (
        output start, btn,
        input  show_valid, show_symbol, level, leds, win, lose
    );

    modport slave (
        input  start, btn,
        output show_valid, show_symbol, level, leds, win, lose
    );

endinterface
`default_nettype wire

// File: rtl/genius_game_fsm_lfsr_seq.sv
`default_nettype none
// ============================================================================
// Module   : genius_lfsr_seq
// Brief    : Pseudo-random symbol sequence source. Reloadable so that the
//            show and input phases replay the same sequence.
// Revision : 1.0 - initial release
// ============================================================================
module genius_lfsr_seq
    import genius_pkg::*;
#(
    parameter int          N_BTN = 3,
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          SYM_W = sym_w_of(N_BTN)
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             load_i,
    input  wire logic [15:0]      seed_i,
    input  wire logic             advance_i,
    output logic      [SYM_W-1:0] symbol_o
);

    logic [15:0] lfsr_q;
    logic [1:0]  w_sym;

    // Load takes priority over advance; the two never coincide in the FSM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else if (load_i) begin
            lfsr_q <= seed_i;
        end else if (advance_i) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign w_sym    = sym_of(lfsr_q, N_BTN);
    assign symbol_o = w_sym[SYM_W-1:0];

endmodule
`default_nettype wire

// File: rtl/genius_game_fsm.sv
`default_nettype none
// ============================================================================
// Module   : genius_game_fsm
// Brief    : Parametrised Simon/Genius game core: shows a growing random
//            sequence, then checks the player's presses against it.
// Revision : 1.0 - initial release
// ============================================================================
module genius_game_fsm
    import genius_pkg::*;
#(
    parameter int          N_BTN         = 3,
    parameter int          MAX_LEVEL     = 16,
    parameter int          SHOW_TICKS    = 50_000_000,
    parameter int          GAP_TICKS     = 12_500_000,
    parameter int          TIMEOUT_TICKS = 250_000_000,
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int          LED_W         = 10
) (
    input  wire logic   clock,
    input  wire logic   reset,
    genius_game_fsm_if.slave bus
);

    localparam int SYM_W = sym_w_of(N_BTN);
    localparam int SHW_W = cnt_w_of(SHOW_TICKS);
    localparam int GAP_W = cnt_w_of(GAP_TICKS);
    localparam int TO_W  = cnt_w_of(TIMEOUT_TICKS);
    localparam int TW_A  = (SHW_W > GAP_W) ? SHW_W : GAP_W;
    localparam int TW    = (TW_A > TO_W) ? TW_A : TO_W;

    state_e            state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [7:0]        level_q, level_d;
    logic [7:0]        idx_q, idx_d;
    logic [LED_W-1:0]  leds_q, leds_d;
    logic [15:0]       seed_q, seed_d;
    logic              win_q, win_d;
    logic              lose_q, lose_d;
    logic [15:0]       free_cnt_q;
    logic              start_q;
    logic [N_BTN-1:0]  btn_prev_q;

    logic              w_load;
    logic [15:0]       w_load_seed;
    logic              w_adv;
    logic [SYM_W-1:0]  w_sym;
    logic              w_start_edge;
    logic              w_press;
    logic              w_correct;
    logic [15:0]       w_new_seed;
    logic [LED_W-1:0]  w_rotl;

    genius_lfsr_seq #(
        .N_BTN (N_BTN),
        .SEED  (SEED),
        .SYM_W (SYM_W)
    ) u_seq (
        .clock     (clock),
        .reset     (reset),
        .load_i    (w_load),
        .seed_i    (w_load_seed),
        .advance_i (w_adv),
        .symbol_o  (w_sym)
    );

    assign w_start_edge = bus.start & ~start_q;
    assign w_press      = (bus.btn != '0) && (btn_prev_q == '0);
    // Exact equality rejects both wrong buttons and multi-button presses.
    assign w_correct    = (bus.btn == (N_BTN'(1) << w_sym));
    assign w_new_seed   = (free_cnt_q == 16'd0) ? SEED : free_cnt_q;
    assign w_rotl       = {leds_q[LED_W-2:0], leds_q[LED_W-1]};

    // Free-running seed source plus edge-detect history for start and buttons.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            free_cnt_q <= 16'd0;
            start_q    <= 1'b0;
            btn_prev_q <= '0;
        end else begin
            free_cnt_q <= free_cnt_q + 16'd1;
            start_q    <= bus.start;
            btn_prev_q <= bus.btn;
        end
    end

    // State register and all game datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            level_q <= 8'd0;
            idx_q   <= 8'd0;
            leds_q  <= '1;
            seed_q  <= SEED;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            level_q <= level_d;
            idx_q   <= idx_d;
            leds_q  <= leds_d;
            seed_q  <= seed_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
        end
    end

    // Next-state, timer, progress and sequence-control logic.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q + 1'b1;
        level_d     = level_q;
        idx_d       = idx_q;
        leds_d      = leds_q;
        seed_d      = seed_q;
        win_d       = 1'b0;
        lose_d      = 1'b0;
        w_load      = 1'b0;
        w_load_seed = seed_q;
        w_adv       = 1'b0;

        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                tick_d = '0;
                if (w_start_edge) begin
                    seed_d      = w_new_seed;
                    w_load      = 1'b1;
                    w_load_seed = w_new_seed;
                    level_d     = 8'd1;
                    idx_d       = 8'd0;
                    leds_d      = LED_W'(1);
                    state_d     = S_SHOW_ON;
                end
            end
            S_SHOW_ON: begin
                if (tick_q == TW'(SHOW_TICKS - 1)) begin
                    tick_d  = '0;
                    w_adv   = 1'b1;
                    idx_d   = idx_q + 8'd1;
                    leds_d  = w_rotl;
                    state_d = S_SHOW_GAP;
                end
            end
            S_SHOW_GAP: begin
                if (tick_q == TW'(GAP_TICKS - 1)) begin
                    tick_d = '0;
                    if (idx_q == level_q) begin
                        // Input phase replays the sequence from the game seed.
                        idx_d   = 8'd0;
                        w_load  = 1'b1;
                        leds_d  = LED_W'(1);
                        state_d = S_WAIT_PRESS;
                    end else begin
                        state_d = S_SHOW_ON;
                    end
                end
            end
            S_WAIT_PRESS: begin
                if (w_press) begin
                    tick_d = '0;
                    if (w_correct) begin
                        w_adv   = 1'b1;
                        idx_d   = idx_q + 8'd1;
                        leds_d  = w_rotl;
                        state_d = S_WAIT_RELEASE;
                    end else begin
                        lose_d  = 1'b1;
                        leds_d  = '0;
                        state_d = S_LOSE;
                    end
                end else if (tick_q == TW'(TIMEOUT_TICKS - 1)) begin
                    lose_d  = 1'b1;
                    leds_d  = '0;
                    state_d = S_LOSE;
                end
            end
            S_WAIT_RELEASE: begin
                tick_d = '0;
                if (bus.btn == '0) begin
                    state_d = (idx_q == level_q) ? S_NEXT_LEVEL : S_WAIT_PRESS;
                end
            end
            S_NEXT_LEVEL: begin
                tick_d = '0;
                if (level_q == 8'(MAX_LEVEL)) begin
                    win_d   = 1'b1;
                    leds_d  = '1;
                    state_d = S_WIN;
                end else begin
                    level_d = level_q + 8'd1;
                    idx_d   = 8'd0;
                    w_load  = 1'b1;
                    leds_d  = LED_W'(1);
                    state_d = S_SHOW_ON;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.show_valid  = (state_q == S_SHOW_ON);
    assign bus.show_symbol = (state_q == S_SHOW_ON) ? w_sym : '0;
    assign bus.level       = level_q;
    assign bus.leds        = leds_q;
    assign bus.win         = win_q;
    assign bus.lose        = lose_q;

endmodule
`default_nettype wire

// File: tb/tb_genius_game_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_genius_game_fsm
// Brief    : Self-checking bench for genius_game_fsm with a spec-level
//            sequence model (small tick parameters, plus an N_BTN=2 build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_genius_game_fsm;
    import genius_pkg::*;

    localparam int N_BTN  = 3;
    localparam int MAXL   = 3;
    localparam int SHOW_T = 4;
    localparam int GAP_T  = 2;
    localparam int TO_T   = 20;
    localparam int LED_W  = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] tb_cnt;
    logic [15:0] cur_seed;
    int          checks = 0;
    int          errors = 0;

    genius_game_fsm_if #(.N_BTN(N_BTN), .LED_W(LED_W)) bus ();
    genius_game_fsm_if #(.N_BTN(2),     .LED_W(LED_W)) bus2 ();

    genius_game_fsm #(
        .N_BTN(N_BTN), .MAX_LEVEL(MAXL), .SHOW_TICKS(SHOW_T), .GAP_TICKS(GAP_T),
        .TIMEOUT_TICKS(TO_T), .SEED(16'hACE1), .LED_W(LED_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    genius_game_fsm #(
        .N_BTN(2), .MAX_LEVEL(MAXL), .SHOW_TICKS(SHOW_T), .GAP_TICKS(GAP_T),
        .TIMEOUT_TICKS(TO_T), .SEED(16'hACE1), .LED_W(LED_W)
    ) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    always #5 clock = ~clock;

    // Cycles since reset release: what the free-running seed counter holds.
    always @(posedge clock or negedge reset) begin
        if (!reset) tb_cnt <= 16'd0;
        else        tb_cnt <= tb_cnt + 16'd1;
    end

    // Reference: symbol number idx of the sequence grown from seed.
    function automatic int m_sym(input logic [15:0] seed, input int idx, input int n);
        logic [15:0] x;
        int s;
        x = seed;
        for (int i = 0; i < idx; i++) begin
            x = x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
        end
        s = (n <= 2) ? int'(x[0]) : int'(x[1:0]);
        if (s >= n) s = s - n;
        return s;
    endfunction

    task automatic do_start(output logic [15:0] eff);
        @(negedge clock);
        eff = (tb_cnt == 16'd0) ? 16'hACE1 : tb_cnt;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    // Entered on the first SHOW_ON cycle; returns on the first gap cycle after the last symbol.
    task automatic observe_show(input int lvl, input logic [15:0] sd);
        int j = 0;
        int run = 0;
        int budget = 400;
        while (j < lvl && budget > 0) begin
            if (bus.show_valid === 1'b1) begin
                checks++;
                if (bus.show_symbol !== 2'(m_sym(sd, j, N_BTN)) || bus.level !== 8'(lvl)) begin
                    errors++;
                    $display("FAIL show_symbol step %0d: got sym %0d level %0d, expected sym %0d level %0d",
                             j, bus.show_symbol, bus.level, m_sym(sd, j, N_BTN), lvl);
                end
                run++;
            end else if (run > 0) begin
                checks++;
                if (run != SHOW_T) begin
                    errors++;
                    $display("FAIL show_len step %0d: got %0d cycles, expected %0d", j, run, SHOW_T);
                end
                j++;
                run = 0;
            end
            if (j < lvl) @(negedge clock);
            budget--;
        end
        if (j < lvl) begin
            errors++;
            $display("FAIL show_timeout: saw %0d symbols, expected %0d", j, lvl);
        end
    endtask

    task automatic to_wait_press();
        repeat (2) @(negedge clock);
        checks++;
        if (bus.leds !== 10'h001 || bus.show_valid !== 1'b0) begin
            errors++;
            $display("FAIL input_entry: leds %h show_valid %b, expected leds 001 show_valid 0",
                     bus.leds, bus.show_valid);
        end
    endtask

    task automatic play_inputs(input int lvl, input logic [15:0] sd);
        for (int k = 0; k < lvl; k++) begin
            bus.btn = 3'(1 << m_sym(sd, k, N_BTN));
            @(negedge clock);
            checks++;
            if (bus.lose !== 1'b0 || bus.leds !== 10'(1 << (k + 1))) begin
                errors++;
                $display("FAIL press_accept k=%0d: lose %b leds %h, expected lose 0 leds %h",
                         k, bus.lose, bus.leds, 10'(1 << (k + 1)));
            end
            bus.btn = '0;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.btn = '0; bus2.start = 1'b0; bus2.btn = '0;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.leds !== 10'h3FF || bus.level !== 8'd0 || bus.show_valid !== 1'b0 ||
            bus.show_symbol !== 2'd0 || bus.win !== 1'b0 || bus.lose !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: leds %h level %0d sv %b win %b lose %b, expected 3ff 0 0 0 0",
                     bus.leds, bus.level, bus.show_valid, bus.win, bus.lose);
        end
        reset = 1'b1;
    endtask

    task automatic test_win();
        int wins = 0;
        logic [15:0] sd;
        repeat ($urandom_range(1, 30)) @(negedge clock);
        do_start(sd);
        for (int lvl = 1; lvl <= MAXL; lvl++) begin
            observe_show(lvl, sd);
            to_wait_press();
            play_inputs(lvl, sd);
            @(negedge clock);
        end
        checks++;
        if (bus.win !== 1'b1 || bus.leds !== 10'h3FF || bus.lose !== 1'b0) begin
            errors++;
            $display("FAIL win_entry: win %b lose %b leds %h, expected 1 0 3ff", bus.win, bus.lose, bus.leds);
        end
        repeat (5) begin
            @(negedge clock);
            if (bus.win === 1'b1) wins++;
        end
        checks++;
        if (wins != 0) begin
            errors++;
            $display("FAIL win_pulse_width: got %0d extra win cycles, expected 0", wins);
        end
    endtask

    task automatic test_wrong();
        int s;
        int w;
        repeat ($urandom_range(1, 20)) @(negedge clock);
        do_start(cur_seed);
        observe_show(1, cur_seed);
        to_wait_press();
        s = m_sym(cur_seed, 0, N_BTN);
        w = (s + 1 + int'($urandom_range(0, 1))) % N_BTN;
        bus.btn = 3'(1 << w);
        @(negedge clock);
        checks++;
        if (bus.lose !== 1'b1 || bus.leds !== 10'h000) begin
            errors++;
            $display("FAIL wrong_press: lose %b leds %h, expected 1 000", bus.lose, bus.leds);
        end
        @(negedge clock);
        checks++;
        if (bus.lose !== 1'b0) begin
            errors++;
            $display("FAIL lose_pulse_width: lose %b, expected 0", bus.lose);
        end
        bus.btn = '0;
        repeat ($urandom_range(0, 5)) @(negedge clock);
        do_start(cur_seed);
        checks++;
        if (bus.level !== 8'd1 || bus.show_valid !== 1'b1) begin
            errors++;
            $display("FAIL restart_level: level %0d sv %b, expected 1 1", bus.level, bus.show_valid);
        end
    endtask

    // Continues the game restarted by test_wrong.
    task automatic test_timeout();
        observe_show(1, cur_seed);
        to_wait_press();
        repeat (TO_T - 1) @(negedge clock);
        checks++;
        if (bus.lose !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: lose %b at cycle 19, expected 0", bus.lose);
        end
        @(negedge clock);
        checks++;
        if (bus.lose !== 1'b1) begin
            errors++;
            $display("FAIL timeout_lose: lose %b at cycle 20, expected 1", bus.lose);
        end
        do_start(cur_seed);
        observe_show(1, cur_seed);
        to_wait_press();
        repeat (TO_T - 1) @(negedge clock);
        bus.btn = 3'(1 << m_sym(cur_seed, 0, N_BTN));
        @(negedge clock);
        checks++;
        if (bus.lose !== 1'b0 || bus.leds !== 10'h002) begin
            errors++;
            $display("FAIL late_press: lose %b leds %h, expected 0 002", bus.lose, bus.leds);
        end
        bus.btn = '0;
        repeat (2) @(negedge clock);
        checks++;
        if (bus.level !== 8'd2 || bus.show_valid !== 1'b1) begin
            errors++;
            $display("FAIL level_up: level %0d sv %b, expected 2 1", bus.level, bus.show_valid);
        end
    endtask

    // Called while the game is showing level 2.
    task automatic test_reset_mid();
        int pulses = 0;
        #2 reset = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.leds !== 10'h3FF || bus.level !== 8'd0 || bus.show_valid !== 1'b0 ||
            bus.win !== 1'b0 || bus.lose !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: leds %h level %0d sv %b win %b lose %b, expected 3ff 0 0 0 0",
                     bus.leds, bus.level, bus.show_valid, bus.win, bus.lose);
        end
        reset = 1'b1;
        repeat (4) begin
            @(negedge clock);
            if (bus.win === 1'b1 || bus.lose === 1'b1 || bus.show_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_idle: %0d active cycles after reset, expected 0", pulses);
        end
    endtask

    task automatic test_multi();
        repeat ($urandom_range(1, 20)) @(negedge clock);
        do_start(cur_seed);
        observe_show(1, cur_seed);
        to_wait_press();
        bus.btn = 3'b011;
        @(negedge clock);
        checks++;
        if (bus.lose !== 1'b1) begin
            errors++;
            $display("FAIL multi_press: lose %b, expected 1", bus.lose);
        end
        bus.btn = '0;
    endtask

    task automatic test_held();
        int s;
        do_start(cur_seed);
        s = m_sym(cur_seed, 0, N_BTN);
        bus.btn = 3'(1 << ((s + 1) % N_BTN));
        observe_show(1, cur_seed);
        to_wait_press();
        repeat (3) @(negedge clock);
        checks++;
        if (bus.lose !== 1'b0 || bus.leds !== 10'h001) begin
            errors++;
            $display("FAIL held_press: lose %b leds %h, expected 0 001", bus.lose, bus.leds);
        end
        bus.btn = '0;
        @(negedge clock);
        bus.btn = 3'(1 << s);
        @(negedge clock);
        checks++;
        if (bus.lose !== 1'b0 || bus.leds !== 10'h002) begin
            errors++;
            $display("FAIL repress: lose %b leds %h, expected 0 002", bus.lose, bus.leds);
        end
        bus.btn = '0;
    endtask

    // Start is already high when reset releases, so the captured count is 0.
    task automatic test_seed0();
        @(negedge clock);
        reset = 1'b0;
        bus.start = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        observe_show(1, 16'hACE1);
        to_wait_press();
        play_inputs(1, 16'hACE1);
        @(negedge clock);
        observe_show(2, 16'hACE1);
        to_wait_press();
        play_inputs(2, 16'hACE1);
    endtask

    task automatic test_nbtn2();
        logic [15:0] sd;
        int b;
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 9)) @(negedge clock);
            @(negedge clock);
            sd = (tb_cnt == 16'd0) ? 16'hACE1 : tb_cnt;
            bus2.start = 1'b1;
            @(negedge clock);
            bus2.start = 1'b0;
            checks++;
            if (bus2.show_valid !== 1'b1 || bus2.show_symbol !== 1'(m_sym(sd, 0, 2))) begin
                errors++;
                $display("FAIL nbtn2_symbol run %0d: sv %b sym %0d, expected 1 %0d",
                         r, bus2.show_valid, bus2.show_symbol, m_sym(sd, 0, 2));
            end
            b = 0;
            while (bus2.lose !== 1'b1 && b < 60) begin
                @(negedge clock);
                b++;
            end
            if (b >= 60) begin
                errors++;
                $display("FAIL nbtn2_timeout run %0d: no lose within 60 cycles", r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_win();
        test_wrong();
        test_timeout();
        test_reset_mid();
        test_multi();
        test_held();
        test_seed0();
        test_nbtn2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
